// File: rtl/clk_mon_pkg.sv
// Shared types for the clock frequency monitor: window FSM states and the
// per-window frequency verdict.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        REPORT
    } mon_state_e;

    typedef enum logic [1:0] {
        V_NONE,
        V_OK,
        V_FAST,
        V_SLOW
    } verdict_e;

    function automatic verdict_e classify(
        input int unsigned count,
        input int unsigned lo,
        input int unsigned hi
    );
        verdict_e v;
        if (count > hi)
            v = V_FAST;
        else if (count < lo)
            v = V_SLOW;
        else
            v = V_OK;
        return v;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, cleared by a
// synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_freq_monitor.sv
// Counts rising edges of mon_clk (sampled as data) over a fixed gate window
// and reports the count with in-range / too-fast / too-slow / stuck verdicts.
module clk_freq_monitor
    import clk_mon_pkg::*;
#(
    parameter  int unsigned GATE_CYCLES  = 64,
    parameter  int unsigned EXP_MIN      = 15,
    parameter  int unsigned EXP_MAX      = 17,
    parameter  int unsigned STUCK_CYCLES = 32,
    localparam int unsigned CW           = $clog2(GATE_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          mon_clk,
    output logic [CW-1:0] edge_count,
    output logic          valid,
    output logic          freq_ok,
    output logic          too_fast,
    output logic          too_slow,
    output logic          stuck
);

    localparam int unsigned GW = $clog2(GATE_CYCLES);
    localparam int unsigned SW = $clog2(STUCK_CYCLES + 1);
    localparam logic [GW-1:0] GATE_LAST   = GW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] EDGE_MAX    = '1;
    localparam logic [SW-1:0] STUCK_LIMIT = SW'(STUCK_CYCLES);

    mon_state_e    state;
    logic          mon_sync;
    logic          mon_prev;
    logic          rise;
    logic [GW-1:0] gate_cnt;
    logic [CW-1:0] edge_cnt;
    logic [CW-1:0] edge_inc;
    logic [SW-1:0] idle_cnt;
    verdict_e      verdict;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (mon_clk),
        .q   (mon_sync)
    );

    always_ff @(posedge clk) begin
        if (rst)
            mon_prev <= 1'b0;
        else
            mon_prev <= mon_sync;
    end

    assign rise = mon_sync & ~mon_prev;

    always_comb begin
        edge_inc = edge_cnt;
        if (rise && (edge_cnt != EDGE_MAX))
            edge_inc = edge_cnt + CW'(1);
    end

    always_comb begin
        verdict = classify(32'(edge_cnt), EXP_MIN, EXP_MAX);
    end

    // REPORT restarts the edge count with its own rise so no edge is lost
    // between back-to-back windows.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            edge_count <= '0;
            valid      <= 1'b0;
            freq_ok    <= 1'b0;
            too_fast   <= 1'b0;
            too_slow   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    if (en)
                        state <= MEASURE;
                end
                MEASURE: begin
                    if (!en) begin
                        state    <= IDLE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                    end else begin
                        edge_cnt <= edge_inc;
                        gate_cnt <= gate_cnt + GW'(1);
                        if (gate_cnt == GATE_LAST)
                            state <= REPORT;
                    end
                end
                REPORT: begin
                    edge_count <= edge_cnt;
                    valid      <= 1'b1;
                    freq_ok    <= (verdict == V_OK);
                    too_fast   <= (verdict == V_FAST);
                    too_slow   <= (verdict == V_SLOW);
                    gate_cnt   <= '0;
                    edge_cnt   <= rise ? CW'(1) : '0;
                    state      <= en ? MEASURE : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en || rise)
            idle_cnt <= '0;
        else if (idle_cnt != STUCK_LIMIT)
            idle_cnt <= idle_cnt + SW'(1);
    end

    assign stuck = (idle_cnt == STUCK_LIMIT);

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Self-checking bench for clk_freq_monitor: 10-unit clk, programmable
// mon_clk generator, per-window expectations queued and popped on valid.
module tb_clk_freq_monitor;

    typedef struct {
        int lo;
        int hi;
        bit ok;
        bit fast;
        bit slow;
        int lat;
    } exp_t;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       en        = 1'b0;
    logic       mon_clk   = 1'b0;
    logic       mon_level = 1'b0;
    int         mon_half  = 20;
    logic [6:0] edge_count;
    logic       valid;
    logic       freq_ok;
    logic       too_fast;
    logic       too_slow;
    logic       stuck;

    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];

    clk_freq_monitor #(
        .GATE_CYCLES  (64),
        .EXP_MIN      (15),
        .EXP_MAX      (17),
        .STUCK_CYCLES (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mon_clk    (mon_clk),
        .edge_count (edge_count),
        .valid      (valid),
        .freq_ok    (freq_ok),
        .too_fast   (too_fast),
        .too_slow   (too_slow),
        .stuck      (stuck)
    );

    always #5 clk = ~clk;

    // mon_half > 0: free-running, toggles kept 2-3 units away from posedge clk.
    // mon_half == 0: mon_clk follows mon_level.
    always begin
        if (mon_half == 0) begin
            #1;
            mon_clk = mon_level;
        end else if (($time % 5) != 2) begin
            #1;
        end else begin
            #(mon_half);
            mon_clk = ~mon_clk;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    // Returns the number of posedges until valid is seen, or -1 on timeout.
    task automatic wait_valid(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (edge_count !== 7'd0) begin fails++; $display("FAIL reset_edge_count got %0d want 0", edge_count); end
        checks++; if (valid    !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (freq_ok  !== 1'b0) begin fails++; $display("FAIL reset_freq_ok got %b want 0", freq_ok); end
        checks++; if (too_fast !== 1'b0) begin fails++; $display("FAIL reset_too_fast got %b want 0", too_fast); end
        checks++; if (too_slow !== 1'b0) begin fails++; $display("FAIL reset_too_slow got %b want 0", too_slow); end
        checks++; if (stuck    !== 1'b0) begin fails++; $display("FAIL reset_stuck got %b want 0", stuck); end
    endtask

    task automatic test_rate(input string name, input int half, input int lo, input int hi,
                             input bit ok, input bit fast, input bit slow);
        int   n;
        int   spent;
        exp_t e;
        mon_half = half;
        do_reset();
        repeat (20) @(posedge clk);
        #1;
        // First window: en is seen in IDLE on the next edge, valid 65 edges later.
        sb.push_back('{lo, hi, ok, fast, slow, 66});
        sb.push_back('{lo, hi, ok, fast, slow, 65});
        sb.push_back('{lo, hi, ok, fast, slow, 65});
        en    = 1'b1;
        spent = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_valid(200, n);
            checks++;
            if (n < 0 || n + spent != e.lat) begin
                fails++; $display("FAIL %s_latency got %0d want %0d", name, (n < 0) ? -1 : n + spent, e.lat);
            end
            checks++;
            if ($isunknown(edge_count) || int'(edge_count) < e.lo || int'(edge_count) > e.hi) begin
                fails++; $display("FAIL %s_count got %0d want %0d..%0d", name, edge_count, e.lo, e.hi);
            end
            checks++;
            if ({freq_ok, too_fast, too_slow} !== {e.ok, e.fast, e.slow}) begin
                fails++; $display("FAIL %s_flags got ok/fast/slow=%b%b%b want %b%b%b", name,
                                  freq_ok, too_fast, too_slow, e.ok, e.fast, e.slow);
            end
            @(posedge clk);
            #1;
            spent = 1;
            checks++;
            if (valid !== 1'b0) begin
                fails++; $display("FAIL %s_valid_width got %b want 0", name, valid);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_stuck();
        mon_half = 20;
        do_reset();
        repeat (10) @(posedge clk);
        #1 en = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (stuck !== 1'b0) begin fails++; $display("FAIL stuck_running got %b want 0", stuck); end
        @(posedge mon_clk);
        mon_level = 1'b0;
        mon_half  = 0;
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk);
            #1;
            if (k == 34) begin
                checks++; if (stuck !== 1'b0) begin fails++; $display("FAIL stuck_early got %b want 0", stuck); end
            end
            if (k == 35) begin
                checks++; if (stuck !== 1'b1) begin fails++; $display("FAIL stuck_assert got %b want 1", stuck); end
            end
        end
        repeat (10) @(posedge clk);
        #1;
        checks++; if (stuck !== 1'b1) begin fails++; $display("FAIL stuck_hold got %b want 1", stuck); end
        mon_half = 20;
        @(posedge mon_clk);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (stuck !== 1'b1) begin fails++; $display("FAIL stuck_before_rise got %b want 1", stuck); end
        @(posedge clk);
        #1;
        checks++; if (stuck !== 1'b0) begin fails++; $display("FAIL stuck_release got %b want 0", stuck); end
        en = 1'b0;
    endtask

    task automatic test_en_abort();
        int n;
        int seen;
        mon_half = 20;
        do_reset();
        repeat (10) @(posedge clk);
        #1 en = 1'b1;
        wait_valid(200, n);
        checks++; if (n != 66) begin fails++; $display("FAIL abort_first_latency got %0d want 66", n); end
        // Drop en while gate_cnt is 30.
        repeat (30) @(posedge clk);
        #1 en = 1'b0;
        seen = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin fails++; $display("FAIL abort_no_valid got %0d pulses want 0", seen); end
        checks++;
        if ($isunknown(edge_count) || edge_count < 7'd16 || edge_count > 7'd17) begin
            fails++; $display("FAIL abort_hold_count got %0d want 16..17", edge_count);
        end
        checks++; if (freq_ok !== 1'b1) begin fails++; $display("FAIL abort_hold_ok got %b want 1", freq_ok); end
        en = 1'b1;
        wait_valid(200, n);
        checks++; if (n != 66) begin fails++; $display("FAIL abort_restart_latency got %0d want 66", n); end
        en = 1'b0;
    endtask

    task automatic test_rst_mid();
        int n;
        mon_half = 20;
        do_reset();
        repeat (10) @(posedge clk);
        #1 en = 1'b1;
        wait_valid(200, n);
        repeat (40) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if ({edge_count, valid, freq_ok, too_fast, too_slow, stuck} !== 12'd0) begin
            fails++; $display("FAIL rst_mid_outputs got count=%0d v=%b ok=%b f=%b s=%b st=%b want all 0",
                              edge_count, valid, freq_ok, too_fast, too_slow, stuck);
        end
        wait_valid(200, n);
        checks++; if (n != 66) begin fails++; $display("FAIL rst_mid_latency got %0d want 66", n); end
        checks++;
        if ($isunknown(edge_count) || edge_count < 7'd16 || edge_count > 7'd17) begin
            fails++; $display("FAIL rst_mid_count got %0d want 16..17", edge_count);
        end
        en = 1'b0;
    endtask

    task automatic test_report_edge();
        int   n;
        exp_t e;
        mon_half  = 0;
        mon_level = 1'b0;
        do_reset();
        repeat (5) @(posedge clk);
        #1 en = 1'b1;
        wait_valid(200, n);
        checks++; if (edge_count !== 7'd0) begin fails++; $display("FAIL redge_idle_count got %0d want 0", edge_count); end
        checks++; if (too_slow !== 1'b1) begin fails++; $display("FAIL redge_idle_slow got %b want 1", too_slow); end
        // A mon_clk rise here reaches the edge detector during the next REPORT cycle.
        repeat (62) @(posedge clk);
        #2 mon_level = 1'b1;
        sb.push_back('{0, 0, 1'b0, 1'b0, 1'b1, 0});
        sb.push_back('{1, 1, 1'b0, 1'b0, 1'b1, 0});
        sb.push_back('{0, 0, 1'b0, 1'b0, 1'b1, 0});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_valid(200, n);
            checks++;
            if (n < 0 || edge_count !== 7'(e.lo)) begin
                fails++; $display("FAIL redge_count got %0d (wait %0d) want %0d", edge_count, n, e.lo);
            end
            checks++;
            if ({freq_ok, too_fast, too_slow} !== {e.ok, e.fast, e.slow}) begin
                fails++; $display("FAIL redge_flags got %b%b%b want %b%b%b",
                                  freq_ok, too_fast, too_slow, e.ok, e.fast, e.slow);
            end
        end
        en        = 1'b0;
        mon_level = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rate("nominal", 20, 16, 17, 1'b1, 1'b0, 1'b0);
        test_rate("slow",    40,  8,  9, 1'b0, 1'b0, 1'b1);
        test_rate("fast",    15, 21, 22, 1'b0, 1'b1, 1'b0);
        test_stuck();
        test_en_abort();
        test_rst_mid();
        test_report_edge();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
